// File: rtl/xnor_popcount_acc_if.sv
// rtl/xnor_popcount_acc_if.sv - beat input and result output handshake bundle for xnor_popcount_acc
interface xnor_popcount_acc_if #(
    parameter int W     = 8,
    parameter int ACC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_match;
    logic             out_err;

    modport master (
        output in_valid, a, b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_match, out_err
    );

    modport slave (
        input  in_valid, a, b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_match, out_err
    );
endinterface

// File: rtl/xnor_popcount_acc.sv
// rtl/xnor_popcount_acc.sv - per-packet XNOR popcount accumulator with threshold flag; XNOR_ACC_ERR_EN enables beat-limit termination
module xnor_popcount_acc #(
    parameter int W         = 8,
    parameter int MAX_BEATS = 16,
    parameter int THRESH    = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    xnor_popcount_acc_if.slave  bus
);
    localparam int ACC_W = $clog2(W * MAX_BEATS + 1);
    localparam int PC_W  = $clog2(W + 1);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   beat_cnt;
    logic [ACC_W-1:0]   sum_q;
    logic               match_q;

    logic               accept;
    logic               out_hs;
    logic               end_pkt;
    logic               force_out;
    logic [PC_W-1:0]    pc;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_base;
    logic [CNT_W-1:0]   cnt_next;

    function automatic logic [PC_W-1:0] popcount(input logic [W-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    assign bus.in_ready  = (state != OUT);
    assign bus.out_valid = (state == OUT);
    assign bus.out_sum   = sum_q;
    assign bus.out_match = match_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign out_hs = bus.out_valid && bus.out_ready;
    assign pc     = popcount(~(bus.a ^ bus.b));

    // A beat taken in IDLE opens a fresh packet, so it ignores stale acc/beat_cnt
    always_comb begin
        acc_next = (state == IDLE) ? ACC_W'(pc) : acc + ACC_W'(pc);
        cnt_base = (state == IDLE) ? '0 : beat_cnt;
        cnt_next = (cnt_base == CNT_W'(MAX_BEATS)) ? cnt_base : cnt_base + 1'b1;
    end

`ifdef XNOR_ACC_ERR_EN
    logic err_q;
    assign force_out   = accept && !bus.in_last && (cnt_next == CNT_W'(MAX_BEATS));
    assign bus.out_err = err_q;

    // Error flag is captured with the result and released on the result handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (out_hs) begin
            err_q <= 1'b0;
        end else if (end_pkt) begin
            err_q <= force_out;
        end
    end
`else
    assign force_out   = 1'b0;
    assign bus.out_err = 1'b0;
`endif

    assign end_pkt = accept && (bus.in_last || force_out);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: collect beats until the packet ends, then hold the result until taken
    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACC: begin
                if (accept) begin
                    state_next = end_pkt ? OUT : ACC;
                end
            end
            OUT: begin
                if (out_hs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Accumulator and beat counter, cleared when the result is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            beat_cnt <= '0;
        end else if (out_hs) begin
            acc      <= '0;
            beat_cnt <= '0;
        end else if (accept) begin
            acc      <= acc_next;
            beat_cnt <= cnt_next;
        end
    end

    // Result registers load on the packet-ending beat and stay frozen through OUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            match_q <= 1'b0;
        end else if (end_pkt) begin
            sum_q   <= acc_next;
            match_q <= (int'(acc_next) >= THRESH);
        end
    end
endmodule

// File: tb/tb_xnor_popcount_acc.sv
// tb/tb_xnor_popcount_acc.sv - scoreboard bench for xnor_popcount_acc
module tb_xnor_popcount_acc;
    localparam int W         = 8;
    localparam int MAX_BEATS = 16;
    localparam int THRESH    = 64;
    localparam int ACC_W     = 8;
`ifdef XNOR_ACC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xnor_popcount_acc_if #(.W(W), .ACC_W(ACC_W)) bus ();

    xnor_popcount_acc #(.W(W), .MAX_BEATS(MAX_BEATS), .THRESH(THRESH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic             match;
        logic             err;
    } res_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   run_sum = 0;
    int   run_cnt = 0;
    bit   rand_ready = 1'b0;
    logic ready_val = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        run_sum = 0;
        run_cnt = 0;
        exp_q.delete();
    endtask

    task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
        res_t r;
        int   wrapped;
        run_sum += $countones(~(a ^ b));
        run_cnt++;
        if (last || (ERR_EN && run_cnt == MAX_BEATS)) begin
            wrapped = run_sum % (1 << ACC_W);
            r.sum   = wrapped[ACC_W-1:0];
            r.match = (wrapped >= THRESH);
            r.err   = ERR_EN && !last;
            exp_q.push_back(r);
            run_sum = 0;
            run_cnt = 0;
        end
    endtask

    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic last, input int gap);
        bit ok;
        int budget;
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.a        = a;
        bus.b        = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        ok           = 1'b0;
        budget       = 0;
        while (!ok && budget < 200) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'($urandom % 2);
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        if (!ok) check("beat_accept_timeout", 32'd0, 32'd1);
        else     model_beat(a, b, last);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 300) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_pending_results", exp_q.size(), 32'd0);
    endtask

    // Result ready pattern, updated mid-cycle so it is stable around each edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rand_ready ? 1'($urandom % 2) : ready_val;
        end
    end

    // Monitor: every result handshake pops and compares one expected result
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_sum", 32'(bus.out_sum), 32'(e.sum));
                    check("result_match", 32'(bus.out_match), 32'(e.match));
                    check("result_err", 32'(bus.out_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic [ACC_W-1:0] held;
        int len;

        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_sum", 32'(bus.out_sum), 32'd0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Reset mid-packet discards partial accumulation
        for (int i = 0; i < 3; i++) send_beat(8'hFF, 8'hFF, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midpkt_rst_out_valid", 32'(bus.out_valid), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset while a result is pending clears it immediately
        ready_val = 1'b0;
        #3;
        send_beat(8'hFF, 8'hFF, 1'b1, 0);
        @(negedge clk);
        check("pend_out_valid_before_rst", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("pend_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("pend_rst_out_sum", 32'(bus.out_sum), 32'd0);
        check("pend_rst_out_match", 32'(bus.out_match), 32'd0);
        model_reset();
        ready_val = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single-beat packet: result the cycle after acceptance
        send_beat(8'hFF, 8'hFF, 1'b1, 0);
        check("one_beat_latency", 32'(bus.out_valid), 32'd1);
        wait_drain();

        // Eight beats of 8 matches each reach the threshold exactly
        for (int i = 0; i < 8; i++) send_beat(8'hA5, 8'hA5, (i == 7), 0);
        wait_drain();

        // Backpressure: result held stable and input blocked
        ready_val = 1'b0;
        #3;
        send_beat(8'hF0, 8'h0F, 1'b0, 0);
        send_beat(8'h00, 8'h00, 1'b1, 0);
        held = bus.out_sum;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_sum_stable", 32'(bus.out_sum), 32'd8);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        check("bp_sum_unchanged", 32'(bus.out_sum), 32'(held));
        @(posedge clk);
        #1;
        ready_val = 1'b1;
        wait_drain();

        // Valid toggled every cycle; idle cycles carry garbage and stray in_last
        for (int i = 0; i < 4; i++) send_beat(8'h0F, 8'h0F, (i == 3), (i == 0) ? 0 : 1);
        wait_drain();

        // Beat limit: sixteen beats with no in_last
        for (int i = 0; i < MAX_BEATS; i++) send_beat(8'h01, 8'h01, 1'b0, 0);
        if (ERR_EN) begin
            check("limit_early_result", 32'(bus.out_valid), 32'd1);
            check("limit_out_err", 32'(bus.out_err), 32'd1);
        end else begin
            check("limit_no_early_result", 32'(bus.out_valid), 32'd0);
            check("limit_out_err_zero", 32'(bus.out_err), 32'd0);
        end
        send_beat(8'h01, 8'h01, 1'b1, 0);
        wait_drain();

        // Randomized packets with random gaps and random downstream readiness
        rand_ready = 1'b1;
        for (int p = 0; p < 30; p++) begin
            len = $urandom_range(1, MAX_BEATS);
            for (int i = 0; i < len; i++) begin
                ra = W'($urandom);
                rb = ($urandom % 2) ? ra ^ W'(1 << ($urandom % W)) : W'($urandom);
                send_beat(ra, rb, (i == len - 1), $urandom_range(0, 2));
            end
        end
        wait_drain();
        rand_ready = 1'b0;
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
